mem_sys_rv: RTL and testbench

MEM_SYS_RV -- requirements
Module: mem_sys_rv

---
 rtl/mem_sys_rv_pkg.sv | 31 +++
 rtl/tx_fifo_4.sv | 45 ++++
 rtl/mem_sys_rv.sv | 104 ++++++++++
 tb/tb_mem_sys_rv.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sys_rv_pkg.sv
// Shared constants for the memory subsystem: MMIO register offsets, STATUS bit
// positions and store-strobe encodings.
package mem_sys_rv_pkg;

    // MMIO register offsets, as word index within the 16-byte window
    localparam logic [1:0] OffTxData = 2'd0;
    localparam logic [1:0] OffStatus = 2'd1;
    localparam logic [1:0] OffCycle  = 2'd2;

    localparam int unsigned StFullBit  = 0;
    localparam int unsigned StEmptyBit = 1;
    localparam int unsigned StOvfBit   = 2;
    localparam int unsigned StCountLsb = 4;

    localparam logic [3:0] StrbNone = 4'b0000;
    localparam logic [3:0] StrbByte = 4'b0001;
    localparam logic [3:0] StrbHalf = 4'b0011;
    localparam logic [3:0] StrbWord = 4'b1111;

    function automatic logic [31:0] status_word(input logic full, input logic empty,
                                                input logic ovf, input logic [2:0] count);
        logic [31:0] w;
        w = '0;
        w[StFullBit]          = full;
        w[StEmptyBit]         = empty;
        w[StOvfBit]           = ovf;
        w[StCountLsb +: 3]    = count;
        return w;
    endfunction

endpackage

// File: rtl/tx_fifo_4.sv
// Four-entry byte FIFO feeding the TX port. A push while full is accepted only
// when a pop frees a slot on the same edge; a pop while empty is ignored.
module tx_fifo_4 (
    input  logic       iwClk,
    input  logic       iwnRst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] push_data,
    output logic [7:0] head_data,
    output logic       full,
    output logic       empty,
    output logic [2:0] count
);

    logic [7:0] slot_q [4];
    logic [1:0] rd_ptr_q, wr_ptr_q;
    logic [2:0] count_q;
    logic       pop_ok, push_ok;

    always_comb begin
        full      = (count_q == 3'd4);
        empty     = (count_q == 3'd0);
        count     = count_q;
        head_data = slot_q[rd_ptr_q];
        pop_ok    = pop && !empty;
        push_ok   = push && (!full || pop_ok);
    end

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'b00, push_ok} - {2'b00, pop_ok};
        end
    end

    always_ff @(posedge iwClk) begin
        if (push_ok) slot_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mem_sys_rv.sv
// Word RAM with byte-lane stores plus a small MMIO window (TX FIFO, STATUS,
// free-running CYCLE counter). Reads are registered with one cycle of latency.
module mem_sys_rv
    import mem_sys_rv_pkg::*;
#(
    parameter int unsigned pMemWords = 4096,
    parameter logic [31:0] pMmioBase = 32'hF000_0000
) (
    input  logic        iwClk,
    input  logic        iwnRst,
    input  logic [31:0] iwReadAddr,
    output logic [31:0] owReadData,
    input  logic [31:0] iwWriteAddr,
    input  logic [31:0] iwWriteData,
    input  logic [3:0]  iwWstrb,
    output logic        owTxValid,
    input  logic        iwTxReady,
    output logic [7:0]  owTxData
);

    localparam int unsigned AddrBits = $clog2(pMemWords);

    logic [31:0] mem [pMemWords];
    logic [31:0] rd_data_q, rd_data_d, cycle_q, status;
    logic        ovf_q, ovf_set, ovf_clr;
    logic        rd_ram, rd_mmio, wr_ram, wr_mmio;
    logic [3:0]  strb_eff;
    logic [31:0] wdata_eff;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic [2:0]  tx_count;
    logic        unused_rd_lsb;

    assign unused_rd_lsb = ^iwReadAddr[1:0];

    always_comb begin
        rd_ram  = (iwReadAddr < pMmioBase) && ({2'b00, iwReadAddr[31:2]} < pMemWords);
        rd_mmio = (iwReadAddr[31:4] == pMmioBase[31:4]);
        wr_ram  = (iwWriteAddr < pMmioBase) && ({2'b00, iwWriteAddr[31:2]} < pMemWords);
        wr_mmio = (iwWriteAddr[31:4] == pMmioBase[31:4]) && (iwWstrb != StrbNone);

        // Lanes shifted past byte 3 fall off the 4-bit result
        strb_eff  = iwWstrb << iwWriteAddr[1:0];
        wdata_eff = iwWriteData << {iwWriteAddr[1:0], 3'b000};

        tx_push = wr_mmio && (iwWriteAddr[3:2] == OffTxData) && iwWstrb[0];
        tx_pop  = !tx_empty && iwTxReady;
        ovf_set = tx_push && tx_full && !tx_pop;
        ovf_clr = wr_mmio && (iwWriteAddr[3:2] == OffStatus) && iwWriteData[StOvfBit];

        status = status_word(tx_full, tx_empty, ovf_q, tx_count);

        rd_data_d = '0;
        if (rd_ram) begin
            rd_data_d = mem[iwReadAddr[AddrBits+1:2]];
        end else if (rd_mmio) begin
            case (iwReadAddr[3:2])
                OffStatus: rd_data_d = status;
                OffCycle:  rd_data_d = cycle_q;
                default:   rd_data_d = '0;
            endcase
        end
    end

    // RAM has no reset; contents survive iwnRst
    always_ff @(posedge iwClk) begin
        if (wr_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_eff[i]) mem[iwWriteAddr[AddrBits+1:2]][8*i +: 8] <= wdata_eff[8*i +: 8];
            end
        end
    end

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            rd_data_q <= '0;
            cycle_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            cycle_q   <= cycle_q + 32'd1;
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    tx_fifo_4 u_tx_fifo (
        .iwClk     (iwClk),
        .iwnRst    (iwnRst),
        .push      (tx_push),
        .pop       (tx_pop),
        .push_data (iwWriteData[7:0]),
        .head_data (owTxData),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    assign owReadData = rd_data_q;
    assign owTxValid  = !tx_empty;

endmodule

// File: tb/tb_mem_sys_rv.sv
// Randomized and directed bench for mem_sys_rv, checked against a behavioural
// model of the RAM, TX queue, overflow flag and cycle counter.
module tb_mem_sys_rv;

    localparam int unsigned MEMW    = 4096;
    localparam logic [31:0] BASE    = 32'hF000_0000;
    localparam logic [31:0] A_TX    = BASE;
    localparam logic [31:0] A_STAT  = BASE + 32'h4;
    localparam logic [31:0] A_CYC   = BASE + 32'h8;
    localparam logic [31:0] A_RSV   = BASE + 32'hC;
    localparam int          NWORDS  = 80;

    logic        iwClk = 1'b0;
    logic        iwnRst = 1'b1;
    logic [31:0] iwReadAddr = A_STAT;
    logic [31:0] owReadData;
    logic [31:0] iwWriteAddr = '0;
    logic [31:0] iwWriteData = '0;
    logic [3:0]  iwWstrb = 4'b0000;
    logic        owTxValid;
    logic        iwTxReady = 1'b0;
    logic [7:0]  owTxData;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] ram_m [NWORDS];
    logic [7:0]  q_m [$];
    bit          ovf_m;
    logic [31:0] cyc_m;

    always #5 iwClk = ~iwClk;

    mem_sys_rv #(
        .pMemWords (MEMW),
        .pMmioBase (BASE)
    ) dut (
        .iwClk       (iwClk),
        .iwnRst      (iwnRst),
        .iwReadAddr  (iwReadAddr),
        .owReadData  (owReadData),
        .iwWriteAddr (iwWriteAddr),
        .iwWriteData (iwWriteData),
        .iwWstrb     (iwWstrb),
        .owTxValid   (owTxValid),
        .iwTxReady   (iwTxReady),
        .owTxData    (owTxData)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic bit in_ram(input logic [31:0] a);
        return (a < BASE) && (int'(a[31:2]) < MEMW);
    endfunction

    function automatic bit in_mmio(input logic [31:0] a);
        return (a & 32'hFFFF_FFF0) == BASE;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int sz;
        sz = q_m.size();
        if (in_ram(a)) return ram_m[a[31:2]];
        if (in_mmio(a)) begin
            if (a[3:2] == 2'd1)
                return 32'((sz << 4) + (ovf_m ? 4 : 0) + (sz == 0 ? 2 : 0) + (sz == 4 ? 1 : 0));
            if (a[3:2] == 2'd2) return cyc_m;
        end
        return 32'h0;
    endfunction

    task automatic model_reset();
        q_m.delete();
        ovf_m = 1'b0;
        cyc_m = '0;
    endtask

    // One clock: apply inputs, predict from pre-edge state, advance, compare
    task automatic step(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input logic rdy);
        logic [31:0] exp_rd;
        int          sz, lane;
        bit          pop, set_ovf, clr_ovf;
        iwReadAddr  = ra;
        iwWriteAddr = wa;
        iwWriteData = wd;
        iwWstrb     = ws;
        iwTxReady   = rdy;
        exp_rd  = model_read(ra);
        sz      = q_m.size();
        pop     = (sz != 0) && rdy;
        set_ovf = 1'b0;
        clr_ovf = 1'b0;
        @(posedge iwClk);
        #1;
        if (pop) void'(q_m.pop_front());
        if (in_ram(wa)) begin
            for (int k = 0; k < 4; k++) begin
                lane = int'(wa[1:0]) + k;
                if (ws[k] && lane < 4) ram_m[wa[31:2]][8*lane +: 8] = wd[8*k +: 8];
            end
        end else if (in_mmio(wa) && ws != 4'b0000) begin
            if (wa[3:2] == 2'd0 && ws[0]) begin
                if (sz < 4 || pop) q_m.push_back(wd[7:0]);
                else set_ovf = 1'b1;
            end
            if (wa[3:2] == 2'd1 && wd[2]) clr_ovf = 1'b1;
        end
        if (set_ovf) ovf_m = 1'b1;
        else if (clr_ovf) ovf_m = 1'b0;
        cyc_m = cyc_m + 32'd1;
        chk("rdata", owReadData, exp_rd);
        chk("txvalid", {31'b0, owTxValid}, {31'b0, q_m.size() != 0});
        if (q_m.size() != 0) chk("txdata", {24'b0, owTxData}, {24'b0, q_m[0]});
    endtask

    task automatic idle(input logic rdy);
        step(A_STAT, 32'h0, 32'h0, 4'b0000, rdy);
    endtask

    initial begin
        logic [3:0]  strbs [4];
        logic [7:0]  order [4];
        logic [31:0] unmapped [3];
        logic [31:0] ra, wa, saved;
        int          sel;
        strbs    = '{4'b0000, 4'b0001, 4'b0011, 4'b1111};
        order    = '{8'h42, 8'h43, 8'h44, 8'h46};
        unmapped = '{32'h0000_4000, 32'h8000_0000, BASE + 32'h10};

        // Power-on reset
        #1 iwnRst = 1'b0;
        #2;
        chk("reset_rdata", owReadData, 32'h0);
        chk("reset_txvalid", {31'b0, owTxValid}, 32'h0);
        repeat (2) @(posedge iwClk);
        #1;
        iwnRst = 1'b1;
        model_reset();

        for (int i = 0; i < NWORDS; i++) step(A_STAT, 32'(i * 4), $urandom, 4'b1111, 1'b0);

        // Byte store into a word
        step(A_STAT, 32'h100, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        step(A_STAT, 32'h102, 32'h0000_0055, 4'b0001, 1'b0);
        step(32'h100, 32'h0, 32'h0, 4'b0000, 1'b0);
        chk("byte_store", owReadData, 32'hDE55_BEEF);

        // Half-word store, then read-before-write on the same address
        step(A_STAT, 32'h102, 32'h0000_A5A5, 4'b0011, 1'b0);
        step(32'h100, 32'h0, 32'h0, 4'b0000, 1'b0);
        chk("half_store", owReadData, 32'hA5A5_BEEF);
        step(32'h100, 32'h100, 32'h1234_5678, 4'b1111, 1'b0);
        chk("rbw_old", owReadData, 32'hA5A5_BEEF);
        step(32'h100, 32'h0, 32'h0, 4'b0000, 1'b0);
        chk("rbw_new", owReadData, 32'h1234_5678);

        // Overflow on a fifth push, then clear
        for (int i = 0; i < 5; i++) step(A_STAT, A_TX, 32'(8'h41 + i), 4'b0001, 1'b0);
        idle(1'b0);
        chk("status_ovf", owReadData, 32'h45);
        step(A_STAT, A_STAT, 32'h4, 4'b1111, 1'b0);
        idle(1'b0);
        chk("status_clr", owReadData, 32'h41);

        // Push into a full FIFO while it pops
        chk("head_41", {24'b0, owTxData}, 32'h41);
        step(A_STAT, A_TX, 32'h46, 4'b0001, 1'b1);
        idle(1'b0);
        chk("status_full_pop", owReadData, 32'h41);
        for (int i = 0; i < 4; i++) begin
            chk("order", {24'b0, owTxData}, {24'b0, order[i]});
            idle(1'b1);
        end
        chk("drained", {31'b0, owTxValid}, 32'h0);

        // Push and ready together on an empty FIFO
        step(A_STAT, A_TX, 32'h77, 4'b0001, 1'b1);
        idle(1'b0);
        chk("status_push_empty", owReadData, 32'h10);
        idle(1'b1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)       ra = {22'b0, 8'($urandom_range(0, NWORDS - 1)), 2'($urandom)};
            else if (sel == 6) ra = A_STAT;
            else if (sel == 7) ra = A_CYC;
            else if (sel == 8) ra = ($urandom_range(0, 1) != 0) ? A_TX : A_RSV;
            else               ra = unmapped[$urandom_range(0, 2)];
            sel = $urandom_range(0, 9);
            if (sel < 5)       wa = {22'b0, 8'($urandom_range(0, NWORDS - 1)), 2'($urandom)};
            else if (sel < 7)  wa = A_TX;
            else if (sel == 7) wa = A_STAT;
            else if (sel == 8) wa = ($urandom_range(0, 1) != 0) ? A_CYC : A_RSV;
            else               wa = unmapped[$urandom_range(0, 2)];
            step(ra, wa, $urandom, strbs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of traffic
        step(A_STAT, A_TX, 32'h99, 4'b0001, 1'b0);
        chk("pre_reset_valid", {31'b0, owTxValid}, 32'h1);
        saved = ram_m[64];
        #2 iwnRst = 1'b0;
        #1;
        chk("mid_reset_valid", {31'b0, owTxValid}, 32'h0);
        chk("mid_reset_rdata", owReadData, 32'h0);
        repeat (2) @(posedge iwClk);
        #1;
        iwnRst = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) step(A_CYC, 32'h0, 32'h0, 4'b0000, 1'b1);
        chk("cycle_after_reset", owReadData, 32'd5);
        step(32'h100, 32'h0, 32'h0, 4'b0000, 1'b0);
        chk("ram_survives_reset", owReadData, saved);

        // Just past the end of RAM
        saved = ram_m[0];
        step(32'(MEMW * 4), 32'h0, 32'h0, 4'b0000, 1'b0);
        chk("unmapped_read", owReadData, 32'h0);
        step(A_STAT, 32'(MEMW * 4), 32'hFFFF_FFFF, 4'b1111, 1'b0);
        step(32'h0, 32'h0, 32'h0, 4'b0000, 1'b0);
        chk("unmapped_write", owReadData, saved);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
